// File: rtl/eth_sw_pkg.sv
// Shared types for the Ethernet switch datapath: beat format and the RX arbiter states.
package eth_sw_pkg;

    localparam int ETH_DATA_W = 64;
    localparam int ETH_KEEP_W = 8;
    // Port tags are carried zero-extended in a fixed-width field.
    localparam int ETH_USER_W = 8;

    typedef struct packed {
        logic [ETH_DATA_W-1:0] tdata;
        logic [ETH_KEEP_W-1:0] tkeep;
        logic                  tlast;
        logic [ETH_USER_W-1:0] tuser;
        logic                  terr;
    } eth_beat_t;

    typedef enum logic [1:0] {
        IDLE,
        XFER,
        DROP
    } arb_state_e;

endpackage

// File: rtl/eth_rx_port_arbiter_if.sv
// Bundle of the per-port MAC receive streams and the merged switch-core stream.
interface eth_rx_port_arbiter_if #(
    parameter int NUM_PORTS = 4,
    parameter int PORT_W    = $clog2(NUM_PORTS)
) ();
    import eth_sw_pkg::*;

    logic [NUM_PORTS-1:0][ETH_DATA_W-1:0] s_axis_tdata;
    logic [NUM_PORTS-1:0][ETH_KEEP_W-1:0] s_axis_tkeep;
    logic [NUM_PORTS-1:0]                 s_axis_tvalid;
    logic [NUM_PORTS-1:0]                 s_axis_tlast;
    logic [NUM_PORTS-1:0]                 s_axis_tready;

    logic [ETH_DATA_W-1:0] m_axis_tdata;
    logic [ETH_KEEP_W-1:0] m_axis_tkeep;
    logic                  m_axis_tvalid;
    logic                  m_axis_tlast;
    logic [PORT_W-1:0]     m_axis_tuser;
    logic                  m_axis_terr;
    logic                  m_axis_tready;

    // MACs and switch core side
    modport master (
        output s_axis_tdata, s_axis_tkeep, s_axis_tvalid, s_axis_tlast, m_axis_tready,
        input  s_axis_tready, m_axis_tdata, m_axis_tkeep, m_axis_tvalid, m_axis_tlast,
               m_axis_tuser, m_axis_terr
    );

    // Arbiter side
    modport slave (
        input  s_axis_tdata, s_axis_tkeep, s_axis_tvalid, s_axis_tlast, m_axis_tready,
        output s_axis_tready, m_axis_tdata, m_axis_tkeep, m_axis_tvalid, m_axis_tlast,
               m_axis_tuser, m_axis_terr
    );

endinterface

// File: rtl/axis_skid_buf.sv
// Two-entry AXI-Stream register slice: a registered output stage plus one overflow entry.
// Upstream ready is registered ("overflow entry empty"), so it never depends on m_ready.
module axis_skid_buf #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] s_data,
    input  logic             s_valid,
    output logic             s_ready,
    output logic [WIDTH-1:0] m_data,
    output logic             m_valid,
    input  logic             m_ready
);

    logic [WIDTH-1:0] hold_data;
    logic             hold_valid;
    logic             push;
    logic             load_out;

    assign s_ready  = ~hold_valid;
    assign push     = s_valid & ~hold_valid;
    assign load_out = ~m_valid | m_ready;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid    <= 1'b0;
            m_data     <= '0;
            hold_valid <= 1'b0;
        end else if (load_out) begin
            if (hold_valid) begin
                m_data     <= hold_data;
                m_valid    <= 1'b1;
                hold_valid <= 1'b0;
            end else begin
                m_valid <= push;
                if (push) begin
                    m_data <= s_data;
                end
            end
        end else if (push) begin
            hold_valid <= 1'b1;
        end
    end

    // NOTE: the overflow payload is not reset; hold_valid alone says whether it is meaningful.
    always_ff @(posedge clk) begin
        if (push && !load_out) begin
            hold_data <= s_data;
        end
    end

endmodule

// File: rtl/eth_rx_port_arbiter.sv
// Packet-level round-robin merge of the MAC receive streams into one port-tagged stream,
// truncating frames longer than MAX_BEATS and flagging them with terr on the forced tlast.
module eth_rx_port_arbiter
    import eth_sw_pkg::*;
#(
    parameter int NUM_PORTS = 4,
    parameter int MAX_BEATS = 1200,
    parameter int PORT_W    = $clog2(NUM_PORTS)
) (
    input  logic                  rx_axis_fifo_aclk,
    input  logic                  rx_axis_aresetn,
    eth_rx_port_arbiter_if.slave  bus,
    output logic [15:0]           trunc_cnt
);

    localparam int                CNT_W     = $clog2(MAX_BEATS + 1);
    localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(MAX_BEATS - 1);
    localparam logic [PORT_W-1:0] LAST_PORT = PORT_W'(NUM_PORTS - 1);

    arb_state_e           state_q, state_d;
    logic [PORT_W-1:0]    grant_q, rr_ptr_q, arb_pick, cand, next_ptr;
    logic                 arb_found;
    logic [CNT_W-1:0]     beat_cnt_q;
    logic [15:0]          trunc_q;
    logic [NUM_PORTS-1:0] ready;
    logic                 skid_ready;
    logic                 push_valid;
    eth_beat_t            push_beat, out_beat;
    logic                 in_valid, in_last, accept, at_limit;

    assign in_valid = bus.s_axis_tvalid[grant_q];
    assign in_last  = bus.s_axis_tlast[grant_q];
    assign at_limit = (beat_cnt_q == LAST_CNT);
    assign next_ptr = (grant_q == LAST_PORT) ? '0 : grant_q + PORT_W'(1);
    assign accept   = in_valid & ((state_q == XFER) ? skid_ready : (state_q == DROP));

    // First valid port at or after rr_ptr, wrapping.
    always_comb begin
        arb_found = 1'b0;
        arb_pick  = rr_ptr_q;
        cand      = rr_ptr_q;
        for (int i = 0; i < NUM_PORTS; i++) begin
            cand = PORT_W'((int'(rr_ptr_q) + i) % NUM_PORTS);
            if (!arb_found && bus.s_axis_tvalid[cand]) begin
                arb_found = 1'b1;
                arb_pick  = cand;
            end
        end
    end

    always_ff @(posedge rx_axis_fifo_aclk or negedge rx_axis_aresetn) begin
        if (!rx_axis_aresetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every combinational output gets a default first, so no path infers a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (arb_found) state_d = XFER;
            XFER: begin
                if (accept && in_last) begin
                    state_d = IDLE;
                end else if (accept && at_limit) begin
                    state_d = DROP;
                end
            end
            DROP: if (accept && in_last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ready      = '0;
        push_valid = 1'b0;
        push_beat  = '0;
        case (state_q)
            XFER: begin
                ready[grant_q]  = skid_ready;
                push_valid      = accept;
                push_beat.tdata = bus.s_axis_tdata[grant_q];
                push_beat.tkeep = bus.s_axis_tkeep[grant_q];
                push_beat.tlast = in_last | at_limit;
                push_beat.tuser = ETH_USER_W'(grant_q);
                push_beat.terr  = at_limit & ~in_last;
            end
            DROP:    ready[grant_q] = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge rx_axis_fifo_aclk or negedge rx_axis_aresetn) begin
        if (!rx_axis_aresetn) begin
            grant_q    <= '0;
            rr_ptr_q   <= '0;
            beat_cnt_q <= '0;
            trunc_q    <= '0;
        end else begin
            if (state_q == IDLE && arb_found) begin
                grant_q    <= arb_pick;
                beat_cnt_q <= '0;
            end
            if (state_q == XFER && accept) begin
                beat_cnt_q <= beat_cnt_q + CNT_W'(1);
            end
            if (state_q != IDLE && accept && in_last) begin
                rr_ptr_q <= next_ptr;
            end
            if (state_q == XFER && accept && at_limit && !in_last && trunc_q != '1) begin
                trunc_q <= trunc_q + 16'd1;
            end
        end
    end

    axis_skid_buf #(
        .WIDTH ($bits(eth_beat_t))
    ) u_skid (
        .clk     (rx_axis_fifo_aclk),
        .rst_n   (rx_axis_aresetn),
        .s_data  (push_beat),
        .s_valid (push_valid),
        .s_ready (skid_ready),
        .m_data  (out_beat),
        .m_valid (bus.m_axis_tvalid),
        .m_ready (bus.m_axis_tready)
    );

    assign bus.s_axis_tready = ready;
    assign bus.m_axis_tdata  = out_beat.tdata;
    assign bus.m_axis_tkeep  = out_beat.tkeep;
    assign bus.m_axis_tlast  = out_beat.tlast;
    assign bus.m_axis_tuser  = PORT_W'(out_beat.tuser);
    assign bus.m_axis_terr   = out_beat.terr;
    assign trunc_cnt         = trunc_q;

endmodule

// File: tb/tb_eth_rx_port_arbiter.sv
// Directed bench for eth_rx_port_arbiter: per-port frame sources, an output capture queue,
// and one task per scenario with inline expected-value comparisons.
`timescale 1ns/1ps
module tb_eth_rx_port_arbiter;
    import eth_sw_pkg::*;

    localparam int NP   = 4;
    localparam int PW   = 2;
    localparam int MAXB = 1200;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] trunc_cnt;

    eth_rx_port_arbiter_if #(.NUM_PORTS(NP), .PORT_W(PW)) bus ();

    eth_rx_port_arbiter #(
        .NUM_PORTS (NP),
        .MAX_BEATS (MAXB),
        .PORT_W    (PW)
    ) dut (
        .rx_axis_fifo_aclk (clk),
        .rx_axis_aresetn   (rst_n),
        .bus               (bus.slave),
        .trunc_cnt         (trunc_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0]   data;
        logic [7:0]    keep;
        logic          last;
        logic [PW-1:0] user;
        logic          err;
        int            cyc;
    } obeat_t;

    obeat_t      outq[$];
    int          tests_run = 0;
    int          tests_failed = 0;
    int          cyc = 0;
    int          rdy_mode = 0;
    int          occ = 0;
    int          occ_viol = 0;
    int          stall_viol = 0;
    int          first_valid_cyc = -1;
    bit          prev_stall = 1'b0;
    logic [76:0] prev_snap = '0;

    int          src_len[NP], src_idx[NP], src_rem[NP], src_fno[NP];
    int          src_gap_at[NP], src_gap_len[NP], src_hold[NP];
    bit          src_gap_done[NP];
    logic [7:0]  src_keep[NP];

    function automatic logic [63:0] mk_data(input int p, input int f, input int i);
        return {8'hA0, 8'(p), 16'(f), 32'(i)};
    endfunction

    function automatic logic [75:0] exp_beat(input int p, input int f, input int i, input int len,
                                             input logic [7:0] lkeep, input logic err);
        logic last;
        last = (i == len - 1);
        return {mk_data(p, f, i), (last ? lkeep : 8'hFF), PW'(p), last, err};
    endfunction

    function automatic logic [75:0] got_beat(input obeat_t ob);
        return {ob.data, ob.keep, ob.user, ob.last, ob.err};
    endfunction

    function automatic logic [76:0] out_snap();
        return {bus.m_axis_tvalid, bus.m_axis_tdata, bus.m_axis_tkeep, bus.m_axis_tuser,
                bus.m_axis_tlast, bus.m_axis_terr};
    endfunction

    task automatic drive_srcs();
        for (int p = 0; p < NP; p++) begin
            if (src_rem[p] > 0 && src_hold[p] == 0) begin
                bus.s_axis_tvalid[p] = 1'b1;
                bus.s_axis_tdata[p]  = mk_data(p, src_fno[p], src_idx[p]);
                bus.s_axis_tlast[p]  = (src_idx[p] == src_len[p] - 1);
                bus.s_axis_tkeep[p]  = bus.s_axis_tlast[p] ? src_keep[p] : 8'hFF;
            end else begin
                bus.s_axis_tvalid[p] = 1'b0;
                bus.s_axis_tdata[p]  = '0;
                bus.s_axis_tlast[p]  = 1'b0;
                bus.s_axis_tkeep[p]  = '0;
            end
        end
        bus.m_axis_tready = (rdy_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
    endtask

    task automatic load(input int p, input int len, input int nfr, input int fno,
                        input logic [7:0] lkeep);
        src_len[p]      = len;
        src_rem[p]      = nfr;
        src_fno[p]      = fno;
        src_idx[p]      = 0;
        src_keep[p]     = lkeep;
        src_gap_at[p]   = -1;
        src_gap_len[p]  = 0;
        src_hold[p]     = 0;
        src_gap_done[p] = 1'b0;
        drive_srcs();
    endtask

    // One clock: sample at the falling edge, advance sources just after the rising edge.
    task automatic step();
        bit     hs[NP];
        bit     ohs;
        obeat_t ob;
        @(negedge clk);
        ohs = bus.m_axis_tvalid && bus.m_axis_tready;
        if (bus.m_axis_tvalid && first_valid_cyc < 0) first_valid_cyc = cyc;
        if (prev_stall && out_snap() != prev_snap) stall_viol++;
        prev_stall = bus.m_axis_tvalid && !bus.m_axis_tready;
        prev_snap  = out_snap();
        if (occ >= 2 && bus.s_axis_tready != '0) occ_viol++;
        if (occ > 2) occ_viol++;
        for (int p = 0; p < NP; p++) hs[p] = bus.s_axis_tvalid[p] && bus.s_axis_tready[p];
        if (ohs) begin
            ob.data = bus.m_axis_tdata;
            ob.keep = bus.m_axis_tkeep;
            ob.last = bus.m_axis_tlast;
            ob.user = bus.m_axis_tuser;
            ob.err  = bus.m_axis_terr;
            ob.cyc  = cyc;
            outq.push_back(ob);
        end
        @(posedge clk);
        #1;
        cyc++;
        for (int p = 0; p < NP; p++) begin
            if (src_hold[p] > 0) src_hold[p]--;
            if (hs[p]) begin
                occ++;
                if (src_idx[p] == src_len[p] - 1) begin
                    src_idx[p] = 0;
                    src_fno[p]++;
                    src_rem[p]--;
                end else begin
                    src_idx[p]++;
                    if (src_idx[p] == src_gap_at[p] && !src_gap_done[p]) begin
                        src_hold[p]     = src_gap_len[p];
                        src_gap_done[p] = 1'b1;
                    end
                end
            end
        end
        if (ohs) occ--;
        drive_srcs();
    endtask

    task automatic run(input int budget, output bit timeout);
        int n;
        bit busy;
        n       = 0;
        timeout = 1'b0;
        forever begin
            busy = bus.m_axis_tvalid;
            for (int p = 0; p < NP; p++) if (src_rem[p] > 0) busy = 1'b1;
            if (!busy) break;
            if (n >= budget) begin
                timeout = 1'b1;
                break;
            end
            step();
            n++;
        end
    endtask

    task automatic test_reset();
        for (int p = 0; p < NP; p++) src_rem[p] = 0;
        rdy_mode = 0;
        rst_n    = 1'b0;
        drive_srcs();
        repeat (2) @(posedge clk);
        #1;
        tests_run++;
        if (out_snap() !== '0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got %h expected 0", out_snap());
        end
        tests_run++;
        if (bus.s_axis_tready !== 4'b0000) begin
            tests_failed++;
            $display("FAIL reset_tready: got %b expected 0000", bus.s_axis_tready);
        end
        tests_run++;
        if (trunc_cnt !== 16'd0) begin
            tests_failed++;
            $display("FAIL reset_trunc_cnt: got %0d expected 0", trunc_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_all_ports();
        bit to;
        int k;
        outq.delete();
        for (int p = 0; p < NP; p++) load(p, 3, 2, 0, 8'hFF);
        run(200, to);
        tests_run++;
        if (to !== 1'b0) begin
            tests_failed++;
            $display("FAIL all_ports_timeout: got %b expected 0", to);
        end
        tests_run++;
        if (outq.size() !== 24) begin
            tests_failed++;
            $display("FAIL all_ports_count: got %0d expected 24", outq.size());
        end
        for (int f = 0; f < 8; f++) begin
            for (int b = 0; b < 3; b++) begin
                k = f * 3 + b;
                if (k < outq.size()) begin
                    tests_run++;
                    if (got_beat(outq[k]) !== exp_beat(f % 4, f / 4, b, 3, 8'hFF, 1'b0)) begin
                        tests_failed++;
                        $display("FAIL all_ports_beat%0d: got %h expected %h", k,
                                 got_beat(outq[k]), exp_beat(f % 4, f / 4, b, 3, 8'hFF, 1'b0));
                    end
                end
            end
            if (f > 0 && f * 3 < outq.size()) begin
                tests_run++;
                if (outq[f * 3].cyc - outq[f * 3 - 1].cyc !== 2) begin
                    tests_failed++;
                    $display("FAIL all_ports_gap%0d: got %0d cycles expected 2", f,
                             outq[f * 3].cyc - outq[f * 3 - 1].cyc);
                end
            end
        end
    endtask

    task automatic test_single_frame();
        bit to;
        int load_cyc;
        outq.delete();
        first_valid_cyc = -1;
        load_cyc        = cyc;
        load(2, 8, 1, 0, 8'h0F);
        run(100, to);
        tests_run++;
        if (outq.size() !== 8 || to !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_count: got %0d beats (timeout %b) expected 8", outq.size(), to);
        end
        tests_run++;
        if (first_valid_cyc - load_cyc !== 2) begin
            tests_failed++;
            $display("FAIL single_latency: got %0d expected 2", first_valid_cyc - load_cyc);
        end
        for (int k = 0; k < outq.size(); k++) begin
            tests_run++;
            if (got_beat(outq[k]) !== exp_beat(2, 0, k, 8, 8'h0F, 1'b0)) begin
                tests_failed++;
                $display("FAIL single_beat%0d: got %h expected %h", k, got_beat(outq[k]),
                         exp_beat(2, 0, k, 8, 8'h0F, 1'b0));
            end
        end
    endtask

    task automatic test_truncation();
        bit to;
        int bad;
        outq.delete();
        load(1, MAXB + 5, 1, 0, 8'hFF);
        run(1400, to);
        tests_run++;
        if (outq.size() !== MAXB || to !== 1'b0) begin
            tests_failed++;
            $display("FAIL trunc_count: got %0d beats (timeout %b) expected %0d", outq.size(), to, MAXB);
        end
        bad = 0;
        foreach (outq[k]) if (got_beat(outq[k]) !== exp_beat(1, 0, k, MAXB, 8'hFF, k == MAXB - 1)) bad++;
        tests_run++;
        if (bad !== 0) begin
            tests_failed++;
            $display("FAIL trunc_beats: got %0d wrong beats expected 0", bad);
        end
        tests_run++;
        if (trunc_cnt !== 16'd1) begin
            tests_failed++;
            $display("FAIL trunc_cnt: got %0d expected 1", trunc_cnt);
        end

        outq.delete();
        load(1, MAXB, 1, 1, 8'hFF);
        run(1400, to);
        tests_run++;
        if (outq.size() !== MAXB || to !== 1'b0) begin
            tests_failed++;
            $display("FAIL max_count: got %0d beats (timeout %b) expected %0d", outq.size(), to, MAXB);
        end
        bad = 0;
        foreach (outq[k]) if (got_beat(outq[k]) !== exp_beat(1, 1, k, MAXB, 8'hFF, 1'b0)) bad++;
        tests_run++;
        if (bad !== 0) begin
            tests_failed++;
            $display("FAIL max_beats: got %0d wrong beats expected 0", bad);
        end
        tests_run++;
        if (trunc_cnt !== 16'd1) begin
            tests_failed++;
            $display("FAIL max_trunc_cnt: got %0d expected 1", trunc_cnt);
        end
    endtask

    task automatic test_backpressure();
        bit to;
        int bad;
        outq.delete();
        rdy_mode   = 1;
        occ        = 0;
        occ_viol   = 0;
        stall_viol = 0;
        prev_stall = 1'b0;
        load(0, 64, 1, 0, 8'hFF);
        run(1000, to);
        rdy_mode = 0;
        drive_srcs();
        tests_run++;
        if (outq.size() !== 64 || to !== 1'b0) begin
            tests_failed++;
            $display("FAIL bp_count: got %0d beats (timeout %b) expected 64", outq.size(), to);
        end
        bad = 0;
        foreach (outq[k]) if (got_beat(outq[k]) !== exp_beat(0, 0, k, 64, 8'hFF, 1'b0)) bad++;
        tests_run++;
        if (bad !== 0) begin
            tests_failed++;
            $display("FAIL bp_beats: got %0d wrong beats expected 0", bad);
        end
        tests_run++;
        if (stall_viol !== 0) begin
            tests_failed++;
            $display("FAIL bp_stable: got %0d changes while stalled expected 0", stall_viol);
        end
        tests_run++;
        if (occ_viol !== 0) begin
            tests_failed++;
            $display("FAIL bp_full_ready: got %0d violations expected 0", occ_viol);
        end
    endtask

    task automatic test_upstream_gaps();
        bit to;
        outq.delete();
        load(3, 12, 1, 0, 8'hFF);
        src_gap_at[3]  = 4;
        src_gap_len[3] = 5;
        load(0, 4, 1, 0, 8'hFF);
        run(200, to);
        tests_run++;
        if (outq.size() !== 16 || to !== 1'b0) begin
            tests_failed++;
            $display("FAIL gap_count: got %0d beats (timeout %b) expected 16", outq.size(), to);
        end
        for (int k = 0; k < outq.size() && k < 16; k++) begin
            tests_run++;
            if (k < 12 ? (got_beat(outq[k]) !== exp_beat(3, 0, k, 12, 8'hFF, 1'b0))
                       : (got_beat(outq[k]) !== exp_beat(0, 0, k - 12, 4, 8'hFF, 1'b0))) begin
                tests_failed++;
                $display("FAIL gap_beat%0d: got %h", k, got_beat(outq[k]));
            end
        end
        if (outq.size() > 4) begin
            tests_run++;
            if (outq[4].cyc - outq[3].cyc !== 6) begin
                tests_failed++;
                $display("FAIL gap_bubble: got %0d cycles expected 6", outq[4].cyc - outq[3].cyc);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        bit to;
        int n;
        outq.delete();
        load(1, 3, 1, 0, 8'hFF);
        run(50, to);
        load(3, 10, 1, 0, 8'hFF);
        n = 0;
        while (src_idx[3] < 4 && n < 30) begin
            step();
            n++;
        end
        tests_run++;
        if (src_idx[3] !== 4) begin
            tests_failed++;
            $display("FAIL rst_reach_beat4: got %0d expected 4", src_idx[3]);
        end
        #2;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (out_snap() !== '0) begin
            tests_failed++;
            $display("FAIL rst_async_outputs: got %h expected 0", out_snap());
        end
        tests_run++;
        if (bus.s_axis_tready !== 4'b0000 || trunc_cnt !== 16'd0) begin
            tests_failed++;
            $display("FAIL rst_async_ready_cnt: got %b/%0d expected 0000/0", bus.s_axis_tready, trunc_cnt);
        end
        for (int p = 0; p < NP; p++) src_rem[p] = 0;
        drive_srcs();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        outq.delete();
        load(3, 3, 1, 0, 8'hFF);
        load(1, 3, 1, 0, 8'hFF);
        run(100, to);
        tests_run++;
        if (outq.size() !== 6 || to !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_after_count: got %0d beats (timeout %b) expected 6", outq.size(), to);
        end
        if (outq.size() == 6) begin
            tests_run++;
            if ({outq[0].user, outq[3].user} !== {2'd1, 2'd3}) begin
                tests_failed++;
                $display("FAIL rst_first_grant: got %0d,%0d expected 1,3", outq[0].user, outq[3].user);
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int p = 0; p < NP; p++) begin
            src_len[p] = 1;  src_idx[p] = 0;  src_rem[p] = 0;  src_fno[p] = 0;
            src_gap_at[p] = -1;  src_gap_len[p] = 0;  src_hold[p] = 0;
            src_gap_done[p] = 1'b0;  src_keep[p] = 8'hFF;
        end
        test_reset();
        test_all_ports();
        test_single_frame();
        test_truncation();
        test_backpressure();
        test_upstream_gaps();
        test_reset_mid_frame();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
